// File: rtl/writeback_ctrl_if.sv
// Register-file write-port bundle: ALU result, load issue/response,
// and the merged write port with hazard/status flags.
interface writeback_ctrl_if #(
  parameter int W = 8,
  parameter int D = 4
);
  logic           AluValid;
  logic [D-1:0]   AluWaddr;
  logic [W-1:0]   AluData;
  logic           LdIssue;
  logic [D-1:0]   LdWaddr;
  logic           MemRdValid;
  logic [W-1:0]   MemRdData;
  logic           WriteEn;
  logic [D-1:0]   Waddr;
  logic [W-1:0]   DataIn;
  logic [2**D-1:0] Pending;
  logic           LdFull;
  logic           Overflow;

  modport master (
    output AluValid, AluWaddr, AluData,
    output LdIssue, LdWaddr,
    output MemRdValid, MemRdData,
    input  WriteEn, Waddr, DataIn,
    input  Pending, LdFull, Overflow
  );

  modport slave (
    input  AluValid, AluWaddr, AluData,
    input  LdIssue, LdWaddr,
    input  MemRdValid, MemRdData,
    output WriteEn, Waddr, DataIn,
    output Pending, LdFull, Overflow
  );
endinterface

// File: rtl/writeback_ctrl.sv
// Write-port driver: ALU results take priority, in-order load queue
// drains one write per cycle and publishes a per-register pending mask.
module writeback_ctrl #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int LQ_DEPTH = 4
) (
  input  logic Clk,
  input  logic Reset,
  writeback_ctrl_if.slave bus
);
  localparam int P  = $clog2(LQ_DEPTH);
  localparam int CW = P + 1;
  localparam int NR = 2**D;

  logic [LQ_DEPTH-1:0] vld;
  logic [LQ_DEPTH-1:0] rdy;
  logic [D-1:0]        addr_q [LQ_DEPTH];
  logic [W-1:0]        data_q [LQ_DEPTH];
  logic [P-1:0]        head;
  logic [P-1:0]        tail;
  logic [P-1:0]        fill;
  logic [CW-1:0]       count;
  logic                ovf;

  logic          full;
  logic          issue_acc;
  logic          fill_ok;
  logic          head_rdy;
  logic          sel_rst;
  logic          sel_alu;
  logic          sel_ld;
  logic [NR-1:0] pend;

  assign full      = (count == CW'(LQ_DEPTH));
  assign issue_acc = bus.LdIssue && !full;
  assign fill_ok   = vld[fill] && !rdy[fill];
  assign head_rdy  = vld[head] && rdy[head];

  // Mutually exclusive selects keep the write-port decoder unique.
  assign sel_rst = !Reset;
  assign sel_alu = Reset && bus.AluValid;
  assign sel_ld  = Reset && !bus.AluValid && head_rdy;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld   <= '0;
      rdy   <= '0;
      head  <= '0;
      tail  <= '0;
      fill  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (issue_acc) begin
        vld[tail] <= 1'b1;
        rdy[tail] <= 1'b0;
        tail      <= tail + P'(1);
      end
      if (bus.MemRdValid) begin
        if (fill_ok) begin
          rdy[fill] <= 1'b1;
          fill      <= fill + P'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
      if (sel_ld) begin
        vld[head] <= 1'b0;
        rdy[head] <= 1'b0;
        head      <= head + P'(1);
      end
      count <= count + CW'(issue_acc) - CW'(sel_ld);
    end
  end

  // Payload needs no reset: it is only read behind valid/ready.
  always_ff @(posedge Clk) begin
    if (issue_acc)
      addr_q[tail] <= bus.LdWaddr;
    if (bus.MemRdValid && fill_ok)
      data_q[fill] <= bus.MemRdData;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (vld[i])
        pend[addr_q[i]] = 1'b1;
  end

  always_comb begin
    bus.WriteEn = 1'b0;
    bus.Waddr   = '0;
    bus.DataIn  = '0;
    unique case (1'b1)
      sel_rst: ;
      sel_alu: begin
        bus.WriteEn = 1'b1;
        bus.Waddr   = bus.AluWaddr;
        bus.DataIn  = bus.AluData;
      end
      sel_ld: begin
        bus.WriteEn = 1'b1;
        bus.Waddr   = addr_q[head];
        bus.DataIn  = data_q[head];
      end
      default: ;
    endcase
  end

  assign bus.Pending  = pend;
  assign bus.LdFull   = full;
  assign bus.Overflow = ovf;
endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl: arbitration, load latency,
// queue full/wrap, overflow and asynchronous reset.
module tb_writeback_ctrl;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LQ = 4;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  writeback_ctrl_if #(.W(W), .D(D)) bus ();

  writeback_ctrl #(
    .W(W), .D(D), .LQ_DEPTH(LQ)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.AluValid   = 1'b0;
    bus.AluWaddr   = '0;
    bus.AluData    = '0;
    bus.LdIssue    = 1'b0;
    bus.LdWaddr    = '0;
    bus.MemRdValid = 1'b0;
    bus.MemRdData  = '0;
  endtask

  task automatic wr(string tag, logic en, logic [D-1:0] a, logic [W-1:0] d);
    chk({tag, "_we"}, 32'(bus.WriteEn), 32'(en));
    chk({tag, "_wa"}, 32'(bus.Waddr), 32'(a));
    chk({tag, "_di"}, 32'(bus.DataIn), 32'(d));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b0;
    idle();
    bus.AluValid = 1'b1;
    bus.AluWaddr = 4'd3;
    bus.AluData  = 8'h5A;
    #2;
    wr("rst", 1'b0, 4'd0, 8'h00);
    chk("rst_pend", 32'(bus.Pending), 32'h0);
    chk("rst_full", 32'(bus.LdFull), 32'h0);
    chk("rst_ovf", 32'(bus.Overflow), 32'h0);
    tick();
    Reset = 1'b1;

    // 1: ALU zero-latency write
    tick();
    #1;
    wr("alu", 1'b1, 4'd3, 8'h5A);
    chk("alu_pend", 32'(bus.Pending), 32'h0);

    // 2: single load r5
    tick();
    idle();
    bus.LdIssue = 1'b1;
    bus.LdWaddr = 4'd5;
    #1;
    chk("l5_pend0", 32'(bus.Pending), 32'h0);
    tick();
    idle();
    #1;
    chk("l5_pend1", 32'(bus.Pending), 32'h20);
    tick();
    tick();
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'hC3;
    #1;
    wr("l5_nobyp", 1'b0, 4'd0, 8'h00);
    tick();
    idle();
    #1;
    wr("l5_wb", 1'b1, 4'd5, 8'hC3);
    chk("l5_pend2", 32'(bus.Pending), 32'h20);
    tick();
    chk("l5_pend3", 32'(bus.Pending), 32'h0);
    wr("l5_idle", 1'b0, 4'd0, 8'h00);

    // 3: ALU priority over ready loads
    bus.LdIssue = 1'b1;
    bus.LdWaddr = 4'd1;
    tick();
    bus.LdWaddr = 4'd2;
    tick();
    idle();
    bus.AluValid   = 1'b1;
    bus.AluWaddr   = 4'd7;
    bus.AluData    = 8'h77;
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'h11;
    #1;
    wr("pri_a", 1'b1, 4'd7, 8'h77);
    chk("pri_pend", 32'(bus.Pending), 32'h06);
    tick();
    bus.MemRdData = 8'h22;
    #1;
    wr("pri_b", 1'b1, 4'd7, 8'h77);
    tick();
    bus.MemRdValid = 1'b0;
    #1;
    wr("pri_c", 1'b1, 4'd7, 8'h77);
    tick();
    idle();
    #1;
    wr("pri_r1", 1'b1, 4'd1, 8'h11);
    tick();
    wr("pri_r2", 1'b1, 4'd2, 8'h22);
    chk("pri_pend2", 32'(bus.Pending), 32'h04);
    tick();
    wr("pri_idle", 1'b0, 4'd0, 8'h00);
    chk("pri_pend3", 32'(bus.Pending), 32'h0);

    // 4a: fill to full, drop fifth issue, drain with wrap
    for (int i = 0; i < 4; i++) begin
      bus.LdIssue = 1'b1;
      bus.LdWaddr = D'(i);
      tick();
    end
    bus.LdWaddr = 4'd9;
    #1;
    chk("full_a", 32'(bus.LdFull), 32'h1);
    chk("full_pa", 32'(bus.Pending), 32'h000F);
    tick();
    idle();
    #1;
    chk("full_b", 32'(bus.LdFull), 32'h1);
    chk("full_p9", 32'(bus.Pending), 32'h000F);
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'hA0;
    #1;
    wr("wq0", 1'b0, 4'd0, 8'h00);
    for (int i = 1; i < 5; i++) begin
      tick();
      bus.MemRdValid = (i < 4);
      bus.MemRdData  = (i < 4) ? 8'hA0 + W'(i) : 8'h00;
      #1;
      wr($sformatf("wq%0d", i), 1'b1, D'(i - 1), 8'hA0 + W'(i - 1));
    end
    tick();
    idle();
    #1;
    wr("wq_idle", 1'b0, 4'd0, 8'h00);
    chk("wq_pend", 32'(bus.Pending), 32'h0);
    chk("wq_full", 32'(bus.LdFull), 32'h0);

    // 4b: drain while full does not admit a same-cycle issue
    for (int i = 8; i < 12; i++) begin
      bus.LdIssue = 1'b1;
      bus.LdWaddr = D'(i);
      tick();
    end
    idle();
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'hB0;
    #1;
    chk("fd_full", 32'(bus.LdFull), 32'h1);
    tick();
    idle();
    bus.LdIssue = 1'b1;
    bus.LdWaddr = 4'd12;
    #1;
    wr("fd_wb", 1'b1, 4'd8, 8'hB0);
    chk("fd_full2", 32'(bus.LdFull), 32'h1);
    tick();
    idle();
    #1;
    chk("fd_pend", 32'(bus.Pending), 32'h0E00);
    chk("fd_full3", 32'(bus.LdFull), 32'h0);
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'hB1;
    #1;
    wr("fd_q0", 1'b0, 4'd0, 8'h00);
    for (int i = 2; i < 5; i++) begin
      tick();
      bus.MemRdValid = (i < 4);
      bus.MemRdData  = (i < 4) ? 8'hB0 + W'(i) : 8'h00;
      #1;
      wr($sformatf("fd_q%0d", i), 1'b1, D'(i + 7), 8'hB0 + W'(i - 1));
    end
    tick();
    idle();
    #1;
    chk("fd_pend2", 32'(bus.Pending), 32'h0);

    // 5: response with empty queue
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'hFF;
    #1;
    chk("ov_pre", 32'(bus.Overflow), 32'h0);
    wr("ov_nowr", 1'b0, 4'd0, 8'h00);
    tick();
    idle();
    #1;
    chk("ov_set", 32'(bus.Overflow), 32'h1);
    wr("ov_nowr2", 1'b0, 4'd0, 8'h00);
    bus.LdIssue = 1'b1;
    bus.LdWaddr = 4'd4;
    tick();
    idle();
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'h44;
    tick();
    idle();
    #1;
    wr("ov_norm", 1'b1, 4'd4, 8'h44);
    chk("ov_stick", 32'(bus.Overflow), 32'h1);

    // 6: async reset with loads outstanding
    tick();
    bus.LdIssue = 1'b1;
    bus.LdWaddr = 4'd6;
    tick();
    bus.LdWaddr    = 4'd7;
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'h66;
    tick();
    idle();
    #1;
    wr("ar_pre", 1'b1, 4'd6, 8'h66);
    chk("ar_pend", 32'(bus.Pending), 32'h00C0);
    #2;
    Reset = 1'b0;
    #1;
    wr("ar_now", 1'b0, 4'd0, 8'h00);
    chk("ar_pend0", 32'(bus.Pending), 32'h0);
    chk("ar_ovf0", 32'(bus.Overflow), 32'h0);
    tick();
    Reset = 1'b1;
    #1;
    chk("ar_pend1", 32'(bus.Pending), 32'h0);
    chk("ar_full", 32'(bus.LdFull), 32'h0);
    wr("ar_idle", 1'b0, 4'd0, 8'h00);
    tick();
    bus.MemRdValid = 1'b1;
    bus.MemRdData  = 8'h77;
    tick();
    idle();
    #1;
    chk("ar_late", 32'(bus.Overflow), 32'h1);
    wr("ar_late_wr", 1'b0, 4'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_ctrl.md
Name: writeback_ctrl

Overview:
- Write-port driver that sits directly upstream of the register file; its WriteEn, Waddr and DataIn connect straight to the register file's write port.
- Merges two result sources:
  - ALU results: single-cycle, always highest priority.
  - Data-memory load responses: multi-cycle, returned in issue order.
- Holds outstanding loads in a small in-order load queue, drains at most one write per cycle, and publishes a per-register pending mask so decode can stall on RAW hazards against in-flight loads.

Parameters:
W, 8, data path width (matches register file)
D, 4, register address width (2**D registers)
LQ_DEPTH, 4, load queue entries (power of two, >=2)

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-low; clears all state
AluValid  input  1  ALU result valid this cycle
AluWaddr  input  D  ALU destination register
AluData  input  W  ALU result
LdIssue  input  1  load issued to memory this cycle
LdWaddr  input  D  load destination register
MemRdValid  input  1  memory returns load data this cycle (in issue order)
MemRdData  input  W  returned load data
WriteEn  output  1  register file write enable
Waddr  output  D  register file write address
DataIn  output  W  register file write data
Pending  output  2**D  bit r set while any queued load targets register r
LdFull  output  1  queue holds LQ_DEPTH entries; LdIssue ignored
Overflow  output  1  sticky error: response arrived with no unfilled entry

Behaviour:
- Queue entry fields: valid, addr[D], data[W], ready.
- Pointers, each log2(LQ_DEPTH) bits, wrapping modulo LQ_DEPTH:
  - head: oldest entry.
  - tail: next free entry.
  - fill: oldest valid entry that is not yet ready.
- count (0..LQ_DEPTH).
- Reset low (async):
  - All valid/ready bits, pointers, count and Overflow cleared.
  - WriteEn=0, Waddr=0, DataIn=0, Pending=0, LdFull=0.
  - Reset asserted mid-operation discards all outstanding loads; late MemRdValid after release with an empty queue sets Overflow.
- Issue:
  - LdIssue && !LdFull: write {valid=1, addr=LdWaddr, ready=0} at tail; tail++.
  - LdIssue && LdFull: dropped. No state change, no error.
  - LdFull = (count==LQ_DEPTH), a registered-state function. A drain in the same cycle does not make room for a same-cycle issue.
- Response:
  - MemRdValid with a valid, not-ready entry at fill: data=MemRdData, ready=1; fill++.
  - MemRdValid with no such entry: data discarded, Overflow<=1 (sticky until reset).
- Write-port arbitration (combinational outputs):
  - AluValid=1: WriteEn=1, Waddr=AluWaddr, DataIn=AluData. Zero-cycle latency; queue does not drain.
  - Else, head entry valid and ready: WriteEn=1, Waddr=head.addr, DataIn=head.data; at clock edge clear head valid/ready, head++.
  - Else: WriteEn=0, Waddr=0, DataIn=0.
- Load latency: response captured at edge N becomes eligible for writeback in cycle N+1. No same-cycle bypass of MemRdData to the write port.
- Simultaneous events in one cycle: issue, fill and drain may all occur. count_next = count + issue_accepted - drain.
- Drain and fill on the same entry cannot happen: drain requires ready, fill requires !ready.
- Pending[r] = OR over valid entries of (addr==r). Combinational from registered queue state, so it updates the cycle after issue or drain.
- Multiple loads to the same register keep Pending[r] set until the last one drains.
- An ALU write to a register with Pending set is performed as presented. Decode guarantees it does not happen; this block does not check for it.
- Wrap-around: pointers wrap silently. Full and empty are distinguished by count only.

Test Plan:
1. Reset low, then high; AluValid=1, AluWaddr=3, AluData=0x5A -> same cycle WriteEn=1, Waddr=3, DataIn=0x5A; Pending=0.
2. LdIssue to r5; 3 cycles later MemRdValid with data 0xC3 -> Pending[5]=1 from cycle after issue; WriteEn=1, Waddr=5, DataIn=0xC3 exactly one cycle after response; Pending[5]=0 the following cycle.
3. Loads to r1 and r2 issued; responses 0x11 and 0x22 arrive while AluValid is held high for 3 cycles (r7) -> r7 writes win every cycle; afterwards r1=0x11 then r2=0x22 on consecutive cycles, in order.
4. Four loads to r0..r3 with no responses -> LdFull=1; fifth LdIssue to r9 -> ignored, Pending[9]=0. Drain all four, issue four more -> pointers wrap; data order preserved.
5. MemRdValid with an empty queue -> Overflow=1 and stays 1 through later normal traffic until Reset low; no write occurs.
6. Two loads outstanding (one ready), Reset pulsed low mid-cycle -> outputs 0 immediately (async); after release Pending=0, LdFull=0; a late MemRdValid sets Overflow.
